xdma_c2h_stream_arbiter: RTL and testbench

// - Shares the single XDMA C2H AXI-Stream channel (s_axis_c2h_*_0) among NUM_SRC line

---
 rtl/xdma_arb_pkg.sv | 20 ++
 rtl/axis_skid_buf.sv | 42 ++++
 rtl/xdma_c2h_stream_arbiter.sv | 96 +++++++++
 tb/tb_xdma_c2h_stream_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xdma_arb_pkg.sv
// xdma_arb_pkg: shared FSM state type and round-robin helper for the C2H stream arbiter.
package xdma_arb_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // Nearest requester after last (wrapping at n); keeps last when nothing requests.
    function automatic logic [2:0] rr_pick(input logic [MAX_SRC-1:0] req, input logic [2:0] last, input int n);
        logic [2:0] pick;
        pick = last;
        for (int k = MAX_SRC; k >= 1; k--) begin
            logic [2:0] idx;
            idx = 3'((int'(last) + k) % n);
            if (k <= n && req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry AXI-Stream register slice; in_ready is a flop, so out_ready
// never reaches the upstream ready combinationally.
module axis_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              out_valid_q, skid_valid_q;
    logic [DATA_W-1:0] out_data_q, skid_data_q;
    logic              load;

    assign load      = out_ready || !out_valid_q;
    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // The skid entry only fills while the output register is stalled.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (load) begin
            out_valid_q  <= skid_valid_q || in_valid;
            out_data_q   <= skid_valid_q ? skid_data_q : in_data;
            skid_valid_q <= 1'b0;
        end else if (in_valid && !skid_valid_q) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= in_data;
        end
    end

endmodule

// File: rtl/xdma_c2h_stream_arbiter.sv
// xdma_c2h_stream_arbiter: packet-locked round-robin share of the XDMA C2H stream among
// NUM_SRC line sources, with a registered output slice and per-source packet counters.
module xdma_c2h_stream_arbiter
    import xdma_arb_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int C_DATA_WIDTH = 64,
    parameter int CNT_W        = 16
) (
    input  logic                            user_clk,
    input  logic                            user_rst,
    input  logic                            user_lnk_up,
    input  logic                            arb_en,
    input  logic [NUM_SRC*C_DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SRC*C_DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_SRC-1:0]              s_tlast,
    input  logic [NUM_SRC-1:0]              s_tvalid,
    output logic [NUM_SRC-1:0]              s_tready,
    output logic [C_DATA_WIDTH-1:0]         m_tdata,
    output logic [C_DATA_WIDTH/8-1:0]       m_tkeep,
    output logic                            m_tlast,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [$clog2(NUM_SRC)-1:0]      grant_idx,
    output logic                            busy,
    output logic [NUM_SRC*CNT_W-1:0]        pkt_cnt
);

    localparam int IDX_W  = $clog2(NUM_SRC);
    localparam int KEEP_W = C_DATA_WIDTH / 8;
    localparam int BEAT_W = C_DATA_WIDTH + KEEP_W + 1;

    arb_state_t               state_q, state_d;
    logic [IDX_W-1:0]         grant_q, grant_d, rr_last_q, rr_last_d;
    logic [NUM_SRC*CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                     sel_valid, sel_last, skid_in_ready, accept;
    logic [BEAT_W-1:0]        sel_beat, out_beat;

    assign sel_valid = (state_q == BUSY) && s_tvalid[grant_q];
    assign sel_last  = s_tlast[grant_q];
    assign sel_beat  = {sel_last, s_tkeep[grant_q*KEEP_W +: KEEP_W], s_tdata[grant_q*C_DATA_WIDTH +: C_DATA_WIDTH]};
    assign accept    = sel_valid && skid_in_ready;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        pkt_cnt_d = pkt_cnt_q;
        s_tready  = '0;
        if (state_q == IDLE) begin
            if (arb_en && user_lnk_up && |s_tvalid) begin
                grant_d = IDX_W'(rr_pick(MAX_SRC'(s_tvalid), 3'(rr_last_q), NUM_SRC));
                state_d = BUSY;
            end
        end else begin
            s_tready[grant_q] = skid_in_ready;
            if (accept && sel_last) begin
                pkt_cnt_d[grant_q*CNT_W +: CNT_W] = pkt_cnt_q[grant_q*CNT_W +: CNT_W] + CNT_W'(1);
                rr_last_d = grant_q;
                state_d   = IDLE;
            end
        end
    end

    // rr_last resets to the top index so source 0 wins the first decision.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_last_q <= IDX_W'(NUM_SRC - 1);
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    axis_skid_buf #(.DATA_W(BEAT_W)) u_skid (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .in_valid  (sel_valid),
        .in_ready  (skid_in_ready),
        .in_data   (sel_beat),
        .out_valid (m_tvalid),
        .out_ready (m_tready),
        .out_data  (out_beat)
    );

    assign {m_tlast, m_tkeep, m_tdata} = out_beat;
    assign busy      = (state_q == BUSY);
    assign grant_idx = grant_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_xdma_c2h_stream_arbiter.sv
// tb_xdma_c2h_stream_arbiter: queue-based reference model of the arbiter (round-robin search,
// 2-deep output FIFO, packet counters) compared every cycle, plus table and directed sequences.
module tb_xdma_c2h_stream_arbiter;

    localparam int NS = 4, DW = 64, KW = 8, CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1, lnk = 1'b1, en = 1'b1, m_tready = 1'b1;
    logic [NS*DW-1:0] s_tdata = '0;
    logic [NS*KW-1:0] s_tkeep = '0;
    logic [NS-1:0]    s_tlast = '0, s_tvalid = '0, s_tready;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tlast, m_tvalid, busy;
    logic [1:0]       grant_idx;
    logic [NS*CW-1:0] pkt_cnt;

    xdma_c2h_stream_arbiter #(.NUM_SRC(NS), .C_DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .user_clk(clk), .user_rst(rst), .user_lnk_up(lnk), .arb_en(en),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .grant_idx(grant_idx), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
    typedef struct packed {logic en; logic lnk; logic [3:0] mask; logic bsy; logic [1:0] g;} vec_t;

    beat_t       srcq[NS][$];
    beat_t       fifo[$];
    beat_t       outq[$];
    logic [NS-1:0] vld = '0;
    bit          m_busy = 0;
    int          m_grant = 0, m_last = NS - 1;
    int          m_cnt[NS];
    int          n_cmp = 0, n_bad = 0, pkt_seq = 0, rdy_mode = 0;
    bit          chk_on = 0, gap_mode = 0, full_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NS-1:0] exp_ready();
        return (m_busy && fifo.size() < 2) ? NS'(1) << m_grant : '0;
    endfunction

    task automatic model_reset();
        fifo.delete();
        m_busy = 0;
        m_grant = 0;
        m_last = NS - 1;
        for (int i = 0; i < NS; i++) m_cnt[i] = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            s_tvalid[i] = vld[i];
            s_tdata[i*DW +: DW] = '0;
            s_tkeep[i*KW +: KW] = '0;
            s_tlast[i] = 1'b0;
            if (vld[i]) begin
                s_tdata[i*DW +: DW] = srcq[i][0].d;
                s_tkeep[i*KW +: KW] = srcq[i][0].k;
                s_tlast[i] = srcq[i][0].l;
            end
        end
    endtask

    task automatic refill();
        for (int i = 0; i < NS; i++)
            if (!vld[i] && srcq[i].size() > 0) vld[i] = gap_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        drive();
    endtask

    task automatic add_pkt(input int s, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = {8'(s), 8'(pkt_seq), 16'(i), 32'($urandom)};
            b.k = 8'($urandom_range(1, 255));
            b.l = (i == n - 1);
            srcq[s].push_back(b);
        end
        pkt_seq++;
        refill();
    endtask

    task automatic check();
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant_idx", 64'(grant_idx), 64'(m_grant));
        chk("s_tready", 64'(s_tready), 64'(exp_ready()));
        chk("m_tvalid", 64'(m_tvalid), 64'(fifo.size() > 0));
        if (fifo.size() > 0) begin
            chk("m_tdata", m_tdata, fifo[0].d);
            chk("m_tkeep", 64'(m_tkeep), 64'(fifo[0].k));
            chk("m_tlast", 64'(m_tlast), 64'(fifo[0].l));
        end
        for (int i = 0; i < NS; i++) chk("pkt_cnt", 64'(pkt_cnt[i*CW +: CW]), 64'(m_cnt[i]));
    endtask

    task automatic cycle();
        logic [NS-1:0] acc;
        bit pop, found;
        beat_t ob;
        @(negedge clk);
        if (chk_on) check();
        if (busy && s_tready == '0) full_seen = 1;
        acc = vld & exp_ready();
        pop = fifo.size() > 0 && m_tready;
        if (m_tvalid && m_tready) begin
            ob = {m_tdata, m_tkeep, m_tlast};
            outq.push_back(ob);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
            for (int i = 0; i < NS; i++) srcq[i].delete();
            vld = '0;
        end else begin
            if (pop) void'(fifo.pop_front());
            if (!m_busy) begin
                found = 0;
                for (int k = 1; k <= NS; k++) begin
                    int j;
                    j = (m_last + k) % NS;
                    if (!found && en && lnk && vld[j]) begin
                        found = 1;
                        m_grant = j;
                        m_busy = 1;
                    end
                end
            end else if (acc[m_grant]) begin
                fifo.push_back(srcq[m_grant][0]);
                if (srcq[m_grant][0].l) begin
                    m_cnt[m_grant] = (m_cnt[m_grant] + 1) % (1 << CW);
                    m_last = m_grant;
                    m_busy = 0;
                end
            end
            for (int i = 0; i < NS; i++)
                if (acc[i]) begin
                    void'(srcq[i].pop_front());
                    vld[i] = 1'b0;
                end
        end
        if (rdy_mode == 1) m_tready = ~m_tready;
        else if (rdy_mode == 2) m_tready = ($urandom_range(0, 3) != 0);
        refill();
    endtask

    task automatic reset_all();
        rst = 1'b1; en = 1'b1; lnk = 1'b1; m_tready = 1'b1;
        rdy_mode = 0; gap_mode = 0;
        cycle();
        cycle();
        chk_on = 1;
        rst = 1'b0;
        outq.delete();
        full_seen = 0;
    endtask

    function automatic bit pending();
        bit p;
        p = m_busy || fifo.size() > 0;
        for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic run_idle(input int max, input string name);
        int c;
        c = 0;
        while (pending() && c < max) begin
            cycle();
            c++;
        end
        chk({name, " timeout"}, 64'(c >= max), 64'(0));
    endtask

    vec_t tbl[8];
    beat_t sent[$];
    int c;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[1] = '{1'b0, 1'b1, 4'b1111, 1'b0, 2'd0};
        tbl[2] = '{1'b1, 1'b0, 4'b1111, 1'b0, 2'd0};
        tbl[3] = '{1'b1, 1'b1, 4'b1010, 1'b1, 2'd1};
        tbl[4] = '{1'b1, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[5] = '{1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[6] = '{1'b1, 1'b1, 4'b1111, 1'b1, 2'd0};
        tbl[7] = '{1'b1, 1'b1, 4'b0110, 1'b1, 2'd1};
        drive();

        for (int t = 0; t < 8; t++) begin
            reset_all();
            en = tbl[t].en;
            lnk = tbl[t].lnk;
            for (int s = 0; s < NS; s++) if (tbl[t].mask[s]) add_pkt(s, 1);
            cycle();
            chk("tbl busy", 64'(busy), 64'(tbl[t].bsy));
            chk("tbl grant", 64'(grant_idx), 64'(tbl[t].g));
        end

        reset_all();
        add_pkt(1, 4);
        run_idle(50, "single");
        chk("single pkt_cnt1", 64'(pkt_cnt[1*CW +: CW]), 64'(1));
        chk("single grant", 64'(grant_idx), 64'(1));
        chk("single beats", 64'(outq.size()), 64'(4));
        if (outq.size() == 4) for (int b = 0; b < 4; b++) chk("single tlast", 64'(outq[b].l), 64'(b == 3));

        reset_all();
        for (int r = 0; r < 2; r++) for (int s = 0; s < NS; s++) add_pkt(s, 2);
        run_idle(200, "fair");
        c = 0;
        for (int i = 0; i < outq.size(); i++)
            if (outq[i].l) begin
                chk("fair order", 64'(outq[i].d[63:56]), 64'(c % 4));
                c++;
            end
        chk("fair pkts", 64'(c), 64'(8));
        for (int s = 0; s < NS; s++) chk("fair pkt_cnt", 64'(pkt_cnt[s*CW +: CW]), 64'(2));

        reset_all();
        rdy_mode = 1;
        add_pkt(0, 8);
        sent = srcq[0];
        run_idle(100, "bp");
        chk("bp beats", 64'(outq.size()), 64'(8));
        if (outq.size() == 8) for (int b = 0; b < 8; b++) chk("bp data", outq[b].d, sent[b].d);
        chk("bp skid full seen", 64'(full_seen), 64'(1));

        reset_all();
        en = 1'b0;
        add_pkt(2, 3);
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("gate s_tready", 64'(s_tready), 64'(0));
            chk("gate m_tvalid", 64'(m_tvalid), 64'(0));
        end
        en = 1'b1;
        cycle();
        chk("gate busy", 64'(busy), 64'(1));
        chk("gate grant", 64'(grant_idx), 64'(2));
        cycle();
        cycle();
        lnk = 1'b0;
        add_pkt(2, 2);
        add_pkt(0, 2);
        for (int i = 0; i < 30; i++) cycle();
        chk("lnk pkt_cnt2", 64'(pkt_cnt[2*CW +: CW]), 64'(1));
        chk("lnk pkt_cnt0", 64'(pkt_cnt[0*CW +: CW]), 64'(0));
        chk("lnk busy", 64'(busy), 64'(0));
        chk("lnk m_tvalid", 64'(m_tvalid), 64'(0));

        reset_all();
        add_pkt(0, 1);
        run_idle(20, "rst pre");
        add_pkt(0, 6);
        c = 0;
        while (srcq[0].size() > 4 && c < 30) begin
            cycle();
            c++;
        end
        chk("rst reach beat3 timeout", 64'(c >= 30), 64'(0));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst pkt_cnt", 64'(pkt_cnt), 64'(0));
        add_pkt(1, 1);
        add_pkt(0, 1);
        cycle();
        chk("rst first grant", 64'(grant_idx), 64'(0));
        run_idle(50, "rst post");

        reset_all();
        for (int i = 0; i < 17; i++) add_pkt(3, 1);
        run_idle(200, "wrap");
        chk("wrap pkt_cnt3", 64'(pkt_cnt[3*CW +: CW]), 64'(1));

        reset_all();
        gap_mode = 1;
        rdy_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                int s;
                s = $urandom_range(0, NS - 1);
                if (srcq[s].size() < 20) add_pkt(s, $urandom_range(1, 5));
            end
            en = ($urandom_range(0, 15) != 0);
            lnk = ($urandom_range(0, 31) != 0);
            cycle();
        end
        en = 1'b1; lnk = 1'b1; gap_mode = 0; rdy_mode = 0; m_tready = 1'b1;
        run_idle(3000, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
